// File: rtl/tc_pkg.sv
// tc_pkg: shared state encoding, register map and CTRL field layout for timer_counter
package tc_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        CNT  = 2'd2,
        INT  = 2'd3
    } state_t;

    localparam logic [1:0] ADDR_CTRL   = 2'd0;
    localparam logic [1:0] ADDR_PRESET = 2'd1;
    localparam logic [1:0] ADDR_COUNT  = 2'd2;

    localparam int CTRL_EN   = 0;
    localparam int CTRL_MODE = 1;
    localparam int CTRL_IM   = 3;

    localparam logic [1:0] MODE_ONESHOT = 2'b00;
    localparam logic [1:0] MODE_AUTO    = 2'b01;

endpackage

// File: rtl/timer_counter.sv
// timer_counter: bridge-mapped down-counter with one-shot / auto-reload modes and maskable irq
module timer_counter
    import tc_pkg::*;
#(
    parameter logic [31:0] PRESET_RST = 32'h0
) (
    input  logic        clk,
    input  logic        sys_rstn,
    input  logic [1:0]  addr,
    input  logic        we,
    input  logic [31:0] din,
    output logic [31:0] dout,
    output logic        irq
);

    state_t      state, state_nxt;
    logic [3:0]  ctrl, ctrl_nxt;
    logic [31:0] preset;
    logic [31:0] count, count_nxt;
    logic        irq_flag, irq_flag_nxt;
    logic        en_clr;
    logic        ctrl_wr;

    // next-state and datapath: a software CTRL write overrides the FSM's own EN clear and irq_flag update
    always_comb begin
        state_nxt    = state;
        count_nxt    = count;
        irq_flag_nxt = irq_flag;
        en_clr       = 1'b0;
        case (state)
            IDLE: state_nxt = ctrl[CTRL_EN] ? LOAD : IDLE;
            LOAD: begin
                count_nxt = preset;
                state_nxt = CNT;
            end
            CNT: begin
                if (!ctrl[CTRL_EN]) begin
                    state_nxt = IDLE;
                end else if (count > 32'd1) begin
                    count_nxt = count - 32'd1;
                end else begin
                    count_nxt    = 32'd0;
                    state_nxt    = INT;
                    irq_flag_nxt = 1'b1;
                end
            end
            INT: begin
                state_nxt = IDLE;
                if (ctrl[CTRL_MODE +: 2] == MODE_AUTO) irq_flag_nxt = 1'b0;
                else en_clr = 1'b1;
            end
        endcase
        ctrl_wr  = we && (addr == ADDR_CTRL);
        ctrl_nxt = ctrl_wr ? din[3:0] : {ctrl[3:1], ctrl[CTRL_EN] & ~en_clr};
        if (ctrl_wr) irq_flag_nxt = 1'b0;
    end

    // state and register file, asynchronously cleared
    always_ff @(posedge clk or negedge sys_rstn) begin
        if (!sys_rstn) begin
            state    <= IDLE;
            ctrl     <= 4'd0;
            preset   <= PRESET_RST;
            count    <= 32'd0;
            irq_flag <= 1'b0;
        end else begin
            state    <= state_nxt;
            ctrl     <= ctrl_nxt;
            count    <= count_nxt;
            irq_flag <= irq_flag_nxt;
            if (we && addr == ADDR_PRESET) preset <= din;
        end
    end

    // read mux follows addr combinationally; COUNT is read-only and the reserved word reads 0
    always_comb begin
        dout = (addr == ADDR_CTRL)   ? {28'd0, ctrl} :
               (addr == ADDR_PRESET) ? preset :
               (addr == ADDR_COUNT)  ? count : 32'd0;
    end

    assign irq = irq_flag & ctrl[CTRL_IM];

endmodule

// File: tb/tb_timer_counter.sv
// tb_timer_counter: vector table, directed corner sequences and random traffic against a reference model
module tb_timer_counter;

    localparam logic [31:0] P_RST = 32'h0000_0003;

    logic        clk = 1'b0;
    logic        sys_rstn = 1'b0;
    logic [1:0]  addr = 2'd0;
    logic        we = 1'b0;
    logic [31:0] din = 32'd0;
    logic [31:0] dout;
    logic        irq;

    int vectors = 0;
    int miscompares = 0;

    timer_counter #(.PRESET_RST(P_RST)) dut (
        .clk(clk), .sys_rstn(sys_rstn), .addr(addr), .we(we),
        .din(din), .dout(dout), .irq(irq)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    // Reference model: the timer as a run of edges counted from arming.
    // k = -1 idle; k = 0 arming edge seen; k = 1 count loaded; counting until k = len+1 (expiry);
    // the edge after expiry ends the run.
    logic [3:0]  m_ctrl;
    logic [31:0] m_preset, m_count, m_p;
    logic        m_flag;
    longint      m_k, m_len;

    task automatic m_reset();
        m_ctrl = 4'd0; m_preset = P_RST; m_count = 32'd0; m_flag = 1'b0;
        m_k = -1; m_len = 1; m_p = 32'd0;
    endtask

    task automatic m_step(input logic w, input logic [1:0] a, input logic [31:0] d);
        logic en, auto_mode, clr_en;
        en = m_ctrl[0];
        auto_mode = (m_ctrl[2:1] == 2'b01);
        clr_en = 1'b0;
        if (m_k < 0) begin
            if (en) m_k = 0;
        end else if (m_k == 0) begin
            m_p = m_preset;
            m_len = (m_preset == 0) ? 1 : longint'(m_preset);
            m_count = m_preset;
            m_k = 1;
        end else if (m_k <= m_len) begin
            if (!en) m_k = -1;
            else begin
                m_k++;
                if (m_k == m_len + 1) begin
                    m_count = 32'd0;
                    m_flag = 1'b1;
                end else m_count = m_p - 32'(m_k - 1);
            end
        end else begin
            m_k = -1;
            if (auto_mode) m_flag = 1'b0;
            else clr_en = 1'b1;
        end
        if (w && a == 2'd0) begin
            m_ctrl = d[3:0];
            m_flag = 1'b0;
        end else if (clr_en) m_ctrl[0] = 1'b0;
        if (w && a == 2'd1) m_preset = d;
    endtask

    function automatic logic [31:0] m_read(input logic [1:0] a);
        return a == 2'd0 ? {28'd0, m_ctrl} : a == 2'd1 ? m_preset : a == 2'd2 ? m_count : 32'd0;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // one clock: drive, clock edge, advance model, settle
    task automatic step(input logic w, input logic [1:0] a, input logic [31:0] d);
        we = w; addr = a; din = d;
        @(posedge clk);
        m_step(w, a, d);
        #1;
        we = 1'b0;
    endtask

    task automatic do_reset();
        sys_rstn = 1'b0; we = 1'b0;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        sys_rstn = 1'b1;
        m_reset();
    endtask

    typedef struct {
        logic        we;
        logic [1:0]  addr;
        logic [31:0] din;
        logic [31:0] exp_dout;
        logic        exp_irq;
    } vec_t;

    function automatic vec_t mk(input logic w, input logic [1:0] a, input logic [31:0] d,
                                input logic [31:0] ed, input logic ei);
        vec_t v;
        v.we = w; v.addr = a; v.din = d; v.exp_dout = ed; v.exp_irq = ei;
        return v;
    endfunction

    vec_t tbl[$];

    initial begin
        m_reset();
        // one-shot PRESET=5, clear, register-map corner cases
        tbl.push_back(mk(1, 1, 32'd5,        32'd5,   0));
        tbl.push_back(mk(1, 0, 32'h9,        32'h9,   0));
        tbl.push_back(mk(0, 2, 32'd0,        32'd0,   0));
        tbl.push_back(mk(0, 2, 32'd0,        32'd5,   0));
        tbl.push_back(mk(0, 2, 32'd0,        32'd4,   0));
        tbl.push_back(mk(0, 2, 32'd0,        32'd3,   0));
        tbl.push_back(mk(0, 2, 32'd0,        32'd2,   0));
        tbl.push_back(mk(0, 2, 32'd0,        32'd1,   0));
        tbl.push_back(mk(0, 2, 32'd0,        32'd0,   1));
        tbl.push_back(mk(0, 0, 32'd0,        32'h8,   1));
        tbl.push_back(mk(0, 0, 32'd0,        32'h8,   1));
        tbl.push_back(mk(1, 0, 32'h0,        32'h0,   0));
        tbl.push_back(mk(0, 2, 32'd0,        32'd0,   0));
        tbl.push_back(mk(1, 2, 32'hFFFF,     32'd0,   0));
        tbl.push_back(mk(1, 3, 32'h1234,     32'd0,   0));
        tbl.push_back(mk(0, 3, 32'd0,        32'd0,   0));
        tbl.push_back(mk(0, 1, 32'd0,        32'd5,   0));
        tbl.push_back(mk(1, 0, 32'hFFFFFFFF, 32'hF,   0));
        tbl.push_back(mk(1, 0, 32'h0,        32'h0,   0));

        do_reset();
        for (int a = 0; a < 4; a++) begin
            addr = 2'(a);
            #1;
            chk($sformatf("reset_dout_a%0d", a), dout, a == 1 ? P_RST : 32'd0);
        end
        chk("reset_irq", {31'd0, irq}, 32'd0);

        for (int i = 0; i < tbl.size(); i++) begin
            step(tbl[i].we, tbl[i].addr, tbl[i].din);
            chk($sformatf("tbl%0d_dout", i), dout, tbl[i].exp_dout);
            chk($sformatf("tbl%0d_irq", i), {31'd0, irq}, {31'd0, tbl[i].exp_irq});
        end

        // auto-reload PRESET=3: single-cycle pulses after edges 5, 11, 17
        do_reset();
        step(1, 1, 32'd3);
        step(1, 0, 32'hB);
        for (int e = 1; e <= 18; e++) begin
            step(0, 0, 32'd0);
            chk($sformatf("auto_irq_e%0d", e), {31'd0, irq}, {31'd0, (e == 5 || e == 11 || e == 17)});
        end
        chk("auto_ctrl_en_kept", dout, 32'hB);

        // PRESET=0 acts as 1: irq after edge 3
        do_reset();
        step(1, 1, 32'd0);
        step(1, 0, 32'h9);
        for (int e = 1; e <= 4; e++) begin
            step(0, 2, 32'd0);
            chk($sformatf("p0_irq_e%0d", e), {31'd0, irq}, {31'd0, e >= 3});
        end

        // disabling mid-count freezes COUNT
        do_reset();
        step(1, 1, 32'd10);
        step(1, 0, 32'h9);
        step(0, 2, 32'd0);
        step(0, 2, 32'd0);
        step(0, 2, 32'd0);
        chk("freeze_e3_count", dout, 32'd9);
        step(1, 0, 32'h8);
        for (int e = 5; e <= 12; e++) begin
            step(0, 2, 32'd0);
            chk($sformatf("freeze_count_e%0d", e), dout, 32'd8);
            chk($sformatf("freeze_irq_e%0d", e), {31'd0, irq}, 32'd0);
        end

        // PRESET write while counting only applies at the next load
        do_reset();
        step(1, 1, 32'd4);
        step(1, 0, 32'hB);
        step(0, 2, 32'd0);
        step(0, 2, 32'd0);
        step(1, 1, 32'd2);
        step(0, 2, 32'd0);
        chk("preset_mid_count", dout, 32'd2);

        // async reset mid-count
        do_reset();
        step(1, 1, 32'd7);
        step(1, 0, 32'h9);
        repeat (4) step(0, 2, 32'd0);
        chk("rst_pre_count", dout, 32'd5);
        #2;
        sys_rstn = 1'b0;
        #1;
        for (int a = 0; a < 3; a++) begin
            addr = 2'(a);
            #1;
            chk($sformatf("async_rst_a%0d", a), dout, a == 1 ? P_RST : 32'd0);
        end
        chk("async_rst_irq", {31'd0, irq}, 32'd0);
        @(negedge clk);
        sys_rstn = 1'b1;
        m_reset();
        for (int e = 1; e <= 20; e++) begin
            step(0, 2, 32'd0);
            chk($sformatf("post_rst_irq_e%0d", e), {31'd0, irq}, 32'd0);
        end
        chk("post_rst_count", dout, 32'd0);

        // random traffic against the reference model
        do_reset();
        for (int i = 0; i < 1500; i++) begin
            logic        w;
            logic [1:0]  a;
            logic [31:0] d;
            w = ($urandom_range(0, 7) == 0);
            a = 2'($urandom_range(0, 3));
            d = $urandom;
            if (a == 2'd1) d = $urandom_range(0, 6);
            if (a == 2'd0) d[0] = ($urandom_range(0, 3) != 0);
            step(w, a, d);
            chk($sformatf("rnd%0d_dout", i), dout, m_read(a));
            chk($sformatf("rnd%0d_irq", i), {31'd0, irq}, {31'd0, m_flag & m_ctrl[3]});
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/timer_counter.md
TIMER_COUNTER -- requirements
Module: timer_counter

Interface
REQ-001 SHALL have parameter PRESET_RST, default 32'h0, reset value of PRESET.
REQ-002 SHALL have port clk  input  1  single system clock; all state on rising edge.
REQ-003 SHALL have port sys_rstn  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port addr  input  2  word select from Bridge (PrAddr[3:2]).
REQ-005 SHALL have port we  input  1  write enable from Bridge, one cycle per write.
REQ-006 SHALL have port din  input  32  write data (PrWD).
REQ-007 SHALL have port dout  output  32  read data to Bridge, combinational on addr.
REQ-008 SHALL have port irq  output  1  interrupt request, drives one HWInt line.

Function
REQ-009 SHALL map registers: addr 0 CTRL (RW), 1 PRESET (RW), 2 COUNT (RO), 3 reserved (reads 0, writes ignored).
REQ-010 SHALL define CTRL: bit0 EN, bits2:1 MODE (00 one-shot, 01 auto-reload, 1x treated as 00), bit3 IM; bits31:4 read 0, write ignored.
REQ-011 SHALL ignore writes to COUNT.
REQ-012 SHALL implement FSM states IDLE, LOAD, CNT, INT.
REQ-013 IDLE: EN=1 -> LOAD next edge; else stay.
REQ-014 LOAD: COUNT<=PRESET, -> CNT.
REQ-015 CNT: EN=0 -> IDLE, COUNT holds; COUNT>1 -> COUNT-1; COUNT<=1 -> COUNT<=0, -> INT, irq_flag<=1.
REQ-016 INT: -> IDLE; MODE one-shot clears EN, irq_flag held; auto-reload keeps EN, clears irq_flag (one-cycle pulse).
REQ-017 SHALL drive irq = irq_flag & CTRL.IM.
REQ-018 Any CTRL write SHALL clear irq_flag.
REQ-019 Latency: CTRL write with EN=1 at edge 0 and PRESET=N>=1 -> irq high after edge N+2; auto-reload period N+3 cycles.
REQ-020 PRESET=0 SHALL behave as PRESET=1 (INT after edge 3).
REQ-021 PRESET write during CNT SHALL affect only the next LOAD.
REQ-022 Simultaneous CTRL write and INT-state EN clear: software write wins.
REQ-023 COUNT arithmetic SHALL be unsigned 32-bit; no wrap below 0.

Reset
REQ-024 On sys_rstn low, asynchronously: state IDLE, CTRL 0, PRESET PRESET_RST, COUNT 0, irq_flag 0, irq 0.
REQ-025 Reset mid-count SHALL abort with no irq after release; dout reflects reset values.
REQ-026 First edge after release SHALL be ordinary operation; no extra synchronizer.

Structure
REQ-027 Shared package tc_pkg SHALL hold state encoding, register offsets, CTRL bit positions, MODE codes.
REQ-028 SHALL be one flat module; no sub-module.
REQ-029 dout mux SHALL be purely combinational; all other outputs registered.

Verification
REQ-030 PRESET=5, CTRL=0x9 at edge 0 -> COUNT 5,4,3,2,1,0 on edges 2..7; irq=1 after edge 7 and held; CTRL reads 0x8 after edge 8.
REQ-031 PRESET=3, CTRL=0xB -> irq one-cycle pulses after edges 5, 11, 17; EN stays 1.
REQ-032 One-shot irq high, write CTRL=0x0 -> irq 0 next cycle; COUNT stays 0.
REQ-033 PRESET=10, CTRL=0x9, write CTRL=0x8 at edge 4 -> state IDLE, COUNT frozen at 8, no irq.
REQ-034 sys_rstn low mid-CNT with PRESET=7 -> all registers reset immediately, irq 0 for 20 cycles after release.
REQ-035 Write COUNT=0xFFFF and addr 3=0x1234 -> reads unchanged and 0; CTRL=0xFFFFFFFF reads 0xF.
